line_buffer_nk: RTL

LINE_BUFFER_NK -- requirements
Module: line_buffer_nk

---
 rtl/lb_pkg.sv | 25 ++
 rtl/lb_row_ram.sv | 25 ++
 rtl/line_buffer_nk.sv | 117 +++++++++++
 3 files changed

// File: rtl/lb_pkg.sv
// Shared definitions for the K-row line buffer: FSM state encoding, default geometry and a width helper.
// Optional top-border replication is selected with LB_BORDER_REPLICATE_EN (see line_buffer_nk).
package lb_pkg;

  localparam int LB_DEF_DW = 8;
  localparam int LB_DEF_W  = 640;
  localparam int LB_DEF_K  = 3;

  typedef logic [1:0] lb_state_t;

  localparam lb_state_t IDLE = 2'd0;
  localparam lb_state_t FILL = 2'd1;
  localparam lb_state_t RUN  = 2'd2;

  // Bits needed to index n items; never returns less than 1 so ports stay legal.
  function automatic int lb_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/lb_row_ram.sv
// One image row of storage: W words of DW bits, combinational read, clocked write.
module lb_row_ram
  import lb_pkg::*;
#(
  parameter int DW = LB_DEF_DW,
  parameter int W  = LB_DEF_W,
  parameter int AW = lb_clog2(LB_DEF_W)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [W];

  // Read is asynchronous, so the old word is seen before the edge that overwrites it.
  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/line_buffer_nk.sv
// K-row raster line buffer producing a vertical column of K taps per incoming pixel.
// Define LB_BORDER_REPLICATE_EN to replicate the oldest real row into not-yet-filled taps instead of zeroing them.
module line_buffer_nk
  import lb_pkg::*;
#(
  parameter int DW = LB_DEF_DW,
  parameter int W  = LB_DEF_W,
  parameter int K  = LB_DEF_K
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DW-1:0]          pixel_in,
  input  logic                   valid_in,
  input  logic                   sof_in,
  output logic [K*DW-1:0]        taps,
  output logic                   win_valid,
  output logic [lb_clog2(W)-1:0] col_out,
  output logic                   eol_out
);

  localparam int CW = lb_clog2(W);
  localparam int FW = lb_clog2(K);
  localparam int R  = K - 1;

  // Handshake: pixel_in/sof_in are consumed on every cycle valid_in is high;
  // there is no backpressure. Outputs describe the pixel presented this cycle.

  logic [CW-1:0] col;
  logic [CW-1:0] eff_col;
  logic [CW-1:0] col_nxt;
  logic [FW-1:0] fill;
  logic [FW-1:0] eff_fill;
  logic [FW-1:0] fill_nxt;
  lb_state_t     state;
  lb_state_t     state_nxt;
  logic          start;
  logic          wrap;
  logic [DW-1:0] row_rd [R];
  logic [DW-1:0] row_wd [R];
  logic [DW-1:0] age_px [K];
  logic [DW-1:0] border_px;

  // A start-of-frame pixel is column 0 of a fresh frame regardless of stored position.
  assign start    = valid_in && sof_in;
  assign eff_col  = start ? '0 : col;
  assign eff_fill = start ? '0 : fill;
  assign wrap     = (eff_col == CW'(W - 1));

  for (genvar i = 0; i < R; i++) begin : g_row
    lb_row_ram #(
      .DW(DW),
      .W (W),
      .AW(CW)
    ) u_row (
      .clk  (clk),
      .we   (valid_in),
      .addr (eff_col),
      .wdata(row_wd[i]),
      .rdata(row_rd[i])
    );
    if (i == 0) begin : g_head
      assign row_wd[i] = pixel_in;
    end else begin : g_chain
      assign row_wd[i] = row_rd[i-1];
    end
  end

  assign age_px[0] = pixel_in;
  for (genvar a = 1; a < K; a++) begin : g_age
    assign age_px[a] = row_rd[a-1];
  end

`ifdef LB_BORDER_REPLICATE_EN
  assign border_px = age_px[eff_fill];
`else
  assign border_px = '0;
`endif

  // Rows older than the fill level hold stale data from a previous frame.
  always_comb begin
    taps = '0;
    for (int a = 0; a < K; a++) begin
      taps[(K-1-a)*DW +: DW] = (a <= int'(eff_fill)) ? age_px[a] : border_px;
    end
  end

  always_comb begin
    col_nxt  = wrap ? '0 : eff_col + CW'(1);
    fill_nxt = eff_fill;
    if (wrap && (eff_fill != FW'(R))) fill_nxt = eff_fill + FW'(1);
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = FILL;
      FILL:    if (fill_nxt == FW'(R)) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
    if (start) state_nxt = FILL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col   <= '0;
      fill  <= '0;
      state <= IDLE;
    end else if (valid_in) begin
      col   <= col_nxt;
      fill  <= fill_nxt;
      state <= state_nxt;
    end
  end

  assign win_valid = valid_in && (state == RUN) && !sof_in;
  assign eol_out   = valid_in && wrap;
  assign col_out   = eff_col;

endmodule
